johnson_phase_monitor: RTL
==========================

Name: johnson_phase_monitor

Overview:
- Sits directly downstream of the 4-bit Johnson ring counter and consumes its parallel code output.
- Decodes each Johnson code to a phase index and a one-hot phase bus that drive downstream multi-phase enables.
- Checks code legality and sequence order, counts full revolutions, and flags a stalled counter.
- All outputs are registered. Errors are reported both as single-cycle pulses and as a sticky flag.

Parameters:
- WIDTH, 4: Johnson code width. The code has 2*WIDTH legal states.
- CNT_W, 8: width of the revolution counter.
- STALL_MAX, 16: number of consecutive cycles at an unchanged phase that raises the stall flag. Must be at least 2.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- jc_in, input, WIDTH: Johnson code from the counter. MSB is the first stage (the stage fed by the inverted last stage).
- err_clr, input, 1: clears err_sticky.
- valid, output, 1: phase outputs are trustworthy.
- phase_idx, output, clog2(2*WIDTH): decoded phase.
- phase_onehot, output, 2*WIDTH: bit phase_idx set. All zero when valid=0.
- illegal_code, output, 1: pulse when the sampled code is not a legal Johnson code.
- seq_error, output, 1: pulse on a legal code that is neither a hold nor phase+1.
- rev_pulse, output, 1: pulse on wrap from phase 2*WIDTH-1 to phase 0.
- rev_count, output, CNT_W: completed revolutions, modulo 2^CNT_W.
- stall, output, 1: level, phase unchanged for at least STALL_MAX cycles.
- err_sticky, output, 1: set by illegal_code or seq_error.

Behaviour:
- Reset: reset is synchronous, active-high; clock is clock. While reset is high at an edge, all outputs are 0, the FSM is in ACQUIRE, and the stall counter is 0.
- Decode (k = phase):
  - For k in 0..WIDTH: top k bits are 1, the rest 0.
  - For k in WIDTH+1..2*WIDTH-1: top k-WIDTH bits are 0, the rest 1.
  - WIDTH=4 gives 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
  - Any other pattern is illegal.
- Latency: jc_in sampled at edge t is reflected on the outputs after edge t, i.e. 1 cycle. Pulses last exactly one cycle.
- FSM states: ACQUIRE and TRACK.
- ACQUIRE:
  - Legal code: load phase_idx, set valid=1, go to TRACK. No seq_error, no rev_pulse.
  - Illegal code: illegal_code pulse, set err_sticky, stay in ACQUIRE.
- TRACK, new phase p versus stored phase q:
  - p == q (hold): increment the stall counter, saturating at STALL_MAX. stall=1 once the count reaches STALL_MAX.
  - p == (q+1) mod 2*WIDTH: normal advance. Stall counter and stall go to 0.
  - If q == 2*WIDTH-1 and p == 0: also rev_pulse=1 and rev_count+1, wrapping to 0 from all-ones.
  - Any other legal p: seq_error pulse, set err_sticky, load p, stay in TRACK, clear the stall counter. No rev_pulse.
  - Illegal code: illegal_code pulse, set err_sticky, valid=0, phase_onehot=0, go to ACQUIRE. phase_idx holds its last value, stall clears, rev_count holds.
- err_sticky:
  - err_clr clears it on the next edge.
  - If an error pulse and err_clr occur in the same cycle, the error wins and err_sticky stays 1.
- Reset mid-operation: everything returns to reset values regardless of state. The first legal code after reset is treated as acquisition, so there is no seq_error for the counter's forced 0000.
- Reset release (for WIDTH=4):
  - The counter outputs 0000 during reset and advances from the first edge after release.
  - The monitor therefore first acquires 0000, phase 0, then tracks 1000.

Test Plan:
- Free-running counter, WIDTH=4, CNT_W=8:
  - phase_idx follows 0,1,..,7,0 with 1-cycle latency.
  - phase_onehot follows 00000001 → 00000010 → ...
  - rev_pulse fires every 8 cycles; rev_count reads 1,2,3. No errors.
- Force jc_in=0101 while tracking:
  - Next cycle: illegal_code=1, valid=0, phase_onehot=0, err_sticky=1.
  - Then jc_in=0011: valid=1, phase_idx=6, seq_error=0.
- Sequence jump 1000→1110:
  - seq_error pulse, phase_idx=3, err_sticky=1, rev_count unchanged.
  - Then 1111 gives a normal advance to phase 4.
- Hold jc_in=1100 for 20 cycles with STALL_MAX=16:
  - stall rises on the 16th hold cycle and stays high.
  - Next jc_in=1110 drops stall and sets phase_idx=3.
- rev_count wrap:
  - Run 256 revolutions; rev_count goes 255→0 on the 256th rev_pulse.
  - Assert reset mid-revolution: all outputs are 0 the next cycle, and reacquisition happens without seq_error.
- Assert err_clr in the same cycle as an illegal code: err_sticky stays 1. Assert err_clr alone on a later cycle: err_sticky goes to 0.

Source files
------------

// File: rtl/johnson_phase_monitor_if.sv
// +--------------------------------------------------------------------------+
// | Module      : johnson_phase_monitor_if                                   |
// | Description : Code input, error clear and decoded phase/status bundle    |
// |               for the Johnson phase monitor.                             |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

interface johnson_phase_monitor_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  localparam int c_nph   = 2 * WIDTH;
  localparam int c_idx_w = $clog2(c_nph);

  logic [WIDTH-1:0]   jc_in;
  logic               err_clr;
  logic               valid;
  logic [c_idx_w-1:0] phase_idx;
  logic [c_nph-1:0]   phase_onehot;
  logic               illegal_code;
  logic               seq_error;
  logic               rev_pulse;
  logic [CNT_W-1:0]   rev_count;
  logic               stall;
  logic               err_sticky;

  // master: counter/consumer side; slave: the monitor itself
  modport master (
    output jc_in, err_clr,
    input  valid, phase_idx, phase_onehot, illegal_code, seq_error,
    input  rev_pulse, rev_count, stall, err_sticky
  );

  modport slave (
    input  jc_in, err_clr,
    output valid, phase_idx, phase_onehot, illegal_code, seq_error,
    output rev_pulse, rev_count, stall, err_sticky
  );
endinterface

`default_nettype wire

// File: rtl/johnson_phase_monitor.sv
// +--------------------------------------------------------------------------+
// | Module      : johnson_phase_monitor                                      |
// | Description : Decodes a Johnson counter code to phase index / one-hot,   |
// |               checks legality and order, counts revolutions, flags stall.|
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module johnson_phase_monitor #(
  parameter int WIDTH     = 4,
  parameter int CNT_W     = 8,
  parameter int STALL_MAX = 16
) (
  input  wire logic               clock,
  input  wire logic               reset,
  johnson_phase_monitor_if.slave  bus
);

  localparam int c_nph     = 2 * WIDTH;
  localparam int c_idx_w   = $clog2(c_nph);
  localparam int c_stall_w = $clog2(STALL_MAX + 1);

  localparam logic [c_stall_w-1:0] c_stall_max = c_stall_w'(STALL_MAX);
  localparam logic [c_stall_w-1:0] c_stall_thr = c_stall_w'(STALL_MAX - 1);
  localparam logic [c_idx_w-1:0]   c_last_ph   = c_idx_w'(c_nph - 1);
  localparam logic [c_nph-1:0]     c_oh_one    = {{(c_nph-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_ACQUIRE = 1'b0,
    ST_TRACK   = 1'b1
  } state_t;

  // Legal code for phase k: ones fill in from the MSB, then zeros do.
  function automatic logic [WIDTH-1:0] f_pattern(input int k);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (k <= WIDTH) p[WIDTH-1-b] = (b < k);
      else            p[WIDTH-1-b] = (b >= k - WIDTH);
    end
    return p;
  endfunction

  state_t               r_state;
  logic                 r_valid;
  logic [c_idx_w-1:0]   r_phase_idx;
  logic [c_nph-1:0]     r_phase_onehot;
  logic                 r_illegal;
  logic                 r_seq_err;
  logic                 r_rev_pulse;
  logic [CNT_W-1:0]     r_rev_count;
  logic                 r_stall;
  logic [c_stall_w-1:0] r_stall_cnt;
  logic                 r_err_sticky;

  logic [c_nph-1:0]     w_match;
  logic                 w_legal;
  logic [c_idx_w-1:0]   w_idx;
  logic [c_nph-1:0]     w_onehot;
  logic [c_idx_w-1:0]   w_succ;
  logic                 w_hold;
  logic                 w_advance;
  logic                 w_err;

  generate
    for (genvar k = 0; k < c_nph; k++) begin : g_decode
      assign w_match[k] = (bus.jc_in == f_pattern(k));
    end
  endgenerate

  always_comb begin
    w_idx = '0;
    for (int k = 0; k < c_nph; k++) begin
      if (w_match[k]) w_idx = c_idx_w'(k);
    end
  end

  assign w_legal   = |w_match;
  assign w_onehot  = c_oh_one << w_idx;
  assign w_succ    = (r_phase_idx == c_last_ph) ? '0 : r_phase_idx + 1'b1;
  assign w_hold    = (w_idx == r_phase_idx);
  assign w_advance = (w_idx == w_succ);
  // Out-of-order jumps only count as errors once a phase has been acquired.
  assign w_err     = !w_legal || ((r_state == ST_TRACK) && !w_hold && !w_advance);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_ACQUIRE;
      r_valid        <= 1'b0;
      r_phase_idx    <= '0;
      r_phase_onehot <= '0;
      r_illegal      <= 1'b0;
      r_seq_err      <= 1'b0;
      r_rev_pulse    <= 1'b0;
      r_rev_count    <= '0;
      r_stall        <= 1'b0;
      r_stall_cnt    <= '0;
      r_err_sticky   <= 1'b0;
    end else begin
      r_illegal   <= 1'b0;
      r_seq_err   <= 1'b0;
      r_rev_pulse <= 1'b0;

      case (r_state)
        ST_ACQUIRE: begin
          if (w_legal) begin
            r_phase_idx    <= w_idx;
            r_phase_onehot <= w_onehot;
            r_valid        <= 1'b1;
            r_stall_cnt    <= '0;
            r_stall        <= 1'b0;
            r_state        <= ST_TRACK;
          end else begin
            r_illegal <= 1'b1;
          end
        end

        ST_TRACK: begin
          if (!w_legal) begin
            // phase_idx deliberately keeps its last value here
            r_illegal      <= 1'b1;
            r_valid        <= 1'b0;
            r_phase_onehot <= '0;
            r_stall_cnt    <= '0;
            r_stall        <= 1'b0;
            r_state        <= ST_ACQUIRE;
          end else if (w_hold) begin
            if (r_stall_cnt != c_stall_max) r_stall_cnt <= r_stall_cnt + 1'b1;
            r_stall <= (r_stall_cnt >= c_stall_thr);
          end else if (w_advance) begin
            r_phase_idx    <= w_idx;
            r_phase_onehot <= w_onehot;
            r_stall_cnt    <= '0;
            r_stall        <= 1'b0;
            if (r_phase_idx == c_last_ph) begin
              r_rev_pulse <= 1'b1;
              r_rev_count <= r_rev_count + 1'b1;
            end
          end else begin
            r_seq_err      <= 1'b1;
            r_phase_idx    <= w_idx;
            r_phase_onehot <= w_onehot;
            r_stall_cnt    <= '0;
            r_stall        <= 1'b0;
          end
        end

        default: r_state <= ST_ACQUIRE;
      endcase

      // A new error outranks a simultaneous clear request.
      if (w_err)            r_err_sticky <= 1'b1;
      else if (bus.err_clr) r_err_sticky <= 1'b0;
    end
  end

  assign bus.valid        = r_valid;
  assign bus.phase_idx    = r_phase_idx;
  assign bus.phase_onehot = r_phase_onehot;
  assign bus.illegal_code = r_illegal;
  assign bus.seq_error    = r_seq_err;
  assign bus.rev_pulse    = r_rev_pulse;
  assign bus.rev_count    = r_rev_count;
  assign bus.stall        = r_stall;
  assign bus.err_sticky   = r_err_sticky;

endmodule

`default_nettype wire
